// File: rtl/d_write_buffer_pkg.sv
// Shared definitions for the D-side write buffer and its arbiter neighbour.
// Contents:
//   WB_* defaults : depth, address/data widths and block-offset size shared with the arbiter
//   wb_state_e    : drain FSM states
//   blk_id()      : cache-block id of a byte address
package d_write_buffer_pkg;

  localparam int unsigned WB_DEPTH   = 4;
  localparam int unsigned WB_ADDR_W  = 16;
  localparam int unsigned WB_DATA_W  = 16;
  localparam int unsigned WB_BLK_OFF = 4;
  // Widest address the block-id helper handles; narrower addresses are zero-extended.
  localparam int unsigned WB_AMAX    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } wb_state_e;

  function automatic logic [WB_AMAX-1:0] blk_id(input logic [WB_AMAX-1:0] addr,
                                                input int unsigned       off);
    return addr >> off;
  endfunction

endpackage

// File: rtl/d_write_buffer_wb_entry_cam.sv
// Address compare array for the write buffer entries.
// Ports:
//   entry_vld_i  : per-entry valid bits
//   entry_addr_i : per-entry store addresses
//   head_i       : index of the head entry (excluded from coalescing)
//   st_addr_i    : incoming store address
//   chk_en_i     : miss check valid
//   chk_addr_i   : D-cache miss address under check
//   coal_oh_o    : one-hot match of st_addr_i against valid non-head entries
//   coal_hit_o   : OR of coal_oh_o
//   blk_hit_o    : some valid entry shares the miss address's cache block
module wb_entry_cam
  import d_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = WB_DEPTH,
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned BLK_OFF = WB_BLK_OFF
) (
  input  logic [DEPTH-1:0]             entry_vld_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_i,
  input  logic [$clog2(DEPTH)-1:0]     head_i,
  input  logic [ADDR_W-1:0]            st_addr_i,
  input  logic                         chk_en_i,
  input  logic [ADDR_W-1:0]            chk_addr_i,
  output logic [DEPTH-1:0]             coal_oh_o,
  output logic                         coal_hit_o,
  output logic                         blk_hit_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WB_AMAX-1:0] chk_blk;
  logic               any_blk;

  always_comb begin
    chk_blk   = blk_id(WB_AMAX'(chk_addr_i), BLK_OFF);
    coal_oh_o = '0;
    any_blk   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      // The head may be on the bus right now, so its data must never change.
      coal_oh_o[i] = entry_vld_i[i] && (head_i != PTR_W'(i)) &&
                     (entry_addr_i[i] == st_addr_i);
      if (entry_vld_i[i] && (blk_id(WB_AMAX'(entry_addr_i[i]), BLK_OFF) == chk_blk)) begin
        any_blk = 1'b1;
      end
    end
    coal_hit_o = |coal_oh_o;
    blk_hit_o  = chk_en_i & any_blk;
  end

endmodule

// File: rtl/d_write_buffer.sv
// Write-through store buffer between the MEM stage and the memory arbiter D port.
// Stores are accepted one per cycle into a circular FIFO and retired one at a
// time under a req/ack handshake. Stores to an address already buffered (other
// than the head) are merged in place. raw_hold tells the fill FSM that a
// buffered store touches the block it wants to fetch.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   st_en, st_addr, st_data       : store request from MEM stage
//   full, empty, count            : occupancy status (registered-state decodes)
//   mem_wr_req/addr/data          : head write offered to the arbiter
//   mem_wr_ack                    : arbiter accepted the head write (1-cycle pulse)
//   miss_chk_en, miss_chk_addr    : pending miss under check
//   raw_hold                      : fill of that miss block must wait
module d_write_buffer
  import d_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = WB_DEPTH,
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned DATA_W  = WB_DATA_W,
  parameter int unsigned BLK_OFF = WB_BLK_OFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_en,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mem_wr_req,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [DATA_W-1:0]      mem_wr_data,
  input  logic                   mem_wr_ack,
  input  logic [ADDR_W-1:0]      miss_chk_addr,
  input  logic                   miss_chk_en,
  output logic                   raw_hold
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_state_e                   state_q, state_d;
  logic [PTR_W-1:0]            head_q, head_d;
  logic [PTR_W-1:0]            tail_q, tail_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0]            vld_q, vld_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  logic             push_ok, pop, alloc;
  logic [DEPTH-1:0] coal_oh;
  logic             coal_hit;

  wb_entry_cam #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .BLK_OFF (BLK_OFF)
  ) u_cam (
    .entry_vld_i  (vld_q),
    .entry_addr_i (addr_q),
    .head_i       (head_q),
    .st_addr_i    (st_addr),
    .chk_en_i     (miss_chk_en),
    .chk_addr_i   (miss_chk_addr),
    .coal_oh_o    (coal_oh),
    .coal_hit_o   (coal_hit),
    .blk_hit_o    (raw_hold)
  );

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  // An ack outside REQ is a stray pulse and must not pop anything.
  assign pop     = (state_q == REQ) && mem_wr_ack;
  assign push_ok = st_en && !full;
  assign alloc   = push_ok && !coal_hit;

  always_comb begin
    state_d = state_q;
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(alloc);
    count_d = count_q;
    vld_d   = vld_q;
    case ({alloc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // A non-full FIFO always has a free slot at tail, distinct from the head.
    if (pop)   vld_d[head_q] = 1'b0;
    if (alloc) vld_d[tail_q] = 1'b1;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = REQ;
      REQ:     if (mem_wr_ack)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Entry payload carries no reset; validity is tracked in vld_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc && (tail_q == PTR_W'(i))) begin
        addr_q[i] <= st_addr;
        data_q[i] <= st_data;
      end else if (push_ok && coal_oh[i]) begin
        data_q[i] <= st_data;
      end
    end
  end

  // Bus outputs are forced to zero when not requesting so that stale payload
  // never appears on the arbiter port, including right after reset.
  always_comb begin
    mem_wr_req  = (state_q == REQ);
    mem_wr_addr = '0;
    mem_wr_data = '0;
    if (state_q == REQ) begin
      mem_wr_addr = addr_q[head_q];
      mem_wr_data = data_q[head_q];
    end
  end

endmodule
